// File: rtl/genie_pkg.sv
// rtl/genie_pkg.sv - shared types for the genie pipeline stage
package genie_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } genie_occ_t;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } genie_pkt_state_t;

endpackage

// File: rtl/genie_pkt_check.sv
// rtl/genie_pkt_check.sv - packet framing and field stability checker
module genie_pkt_check
    import genie_pkg::*;
#(
    parameter int WIDTH_FIELD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   accept,
    input  logic                   sop,
    input  logic                   eop,
    input  logic [WIDTH_FIELD-1:0] field,
    output logic                   err
);

    genie_pkt_state_t        r_state;
    logic [WIDTH_FIELD-1:0]  r_field;
    logic                    r_err;

    // Track packet framing on accepted beats; any violation latches the sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= PKT_IDLE;
            r_field <= '0;
            r_err   <= 1'b0;
        end else if (accept) begin
            case (r_state)
                PKT_IDLE: begin
                    if (sop) begin
                        if (!eop) begin
                            r_state <= PKT_IN;
                            r_field <= field;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                PKT_IN: begin
                    if (sop) begin
                        // A new sop mid-packet restarts tracking from this beat
                        r_err   <= 1'b1;
                        r_field <= field;
                        r_state <= eop ? PKT_IDLE : PKT_IN;
                    end else begin
                        if (field != r_field) begin
                            r_err <= 1'b1;
                        end
                        if (eop) begin
                            r_state <= PKT_IDLE;
                        end
                    end
                end
                default: r_state <= PKT_IDLE;
            endcase
        end
    end

    assign err = r_err;

endmodule

// File: rtl/genie_pipe_stage.sv
// rtl/genie_pipe_stage.sv - registered elastic skid stage with packet checker
module genie_pipe_stage
    import genie_pkg::*;
#(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_FIELD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_DATA-1:0]  i_data,
    input  logic [WIDTH_FIELD-1:0] i_field,
    input  logic                   i_sop,
    input  logic                   i_eop,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [WIDTH_DATA-1:0]  o_data,
    output logic [WIDTH_FIELD-1:0] o_field,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_err
);

    localparam int W_BEAT = WIDTH_DATA + WIDTH_FIELD + 2;

    genie_occ_t          r_occ;
    genie_occ_t          w_occ_nxt;
    logic [W_BEAT-1:0]   r_m;
    logic [W_BEAT-1:0]   r_s;
    logic                r_valid;
    logic                r_ready;
    logic [W_BEAT-1:0]   w_in;
    logic                w_accept;
    logic                w_emit;

    assign w_in     = {i_data, i_field, i_sop, i_eop};
    assign w_accept = i_valid && r_ready;
    assign w_emit   = r_valid && i_ready;

    // Next occupancy from the accept/emit pair seen this cycle
    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            OCC_EMPTY: if (w_accept) w_occ_nxt = OCC_ONE;
            OCC_ONE: begin
                if (w_accept && !w_emit) begin
                    w_occ_nxt = OCC_FULL;
                end else if (!w_accept && w_emit) begin
                    w_occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: if (w_emit) w_occ_nxt = OCC_ONE;
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    // Main/skid entry datapath with registered valid and ready derived from next occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ   <= OCC_EMPTY;
            r_m     <= '0;
            r_s     <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != OCC_EMPTY);
            r_ready <= (w_occ_nxt != OCC_FULL);
            case (r_occ)
                OCC_EMPTY: if (w_accept) r_m <= w_in;
                OCC_ONE: begin
                    if (w_accept && w_emit) begin
                        r_m <= w_in;
                    end else if (w_accept) begin
                        r_s <= w_in;
                    end
                end
                OCC_FULL: if (w_emit) r_m <= r_s;
                default: ;
            endcase
        end
    end

    assign {o_data, o_field, o_sop, o_eop} = r_m;
    assign o_valid = r_valid;
    assign o_ready = r_ready;

    genie_pkt_check #(
        .WIDTH_FIELD (WIDTH_FIELD)
    ) u_pkt_check (
        .clk    (clk),
        .reset  (reset),
        .accept (w_accept),
        .sop    (i_sop),
        .eop    (i_eop),
        .field  (i_field),
        .err    (o_err)
    );

endmodule

// File: tb/tb_genie_pipe_stage.sv
// tb/tb_genie_pipe_stage.sv - scoreboard bench for genie_pipe_stage
module tb_genie_pipe_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_data = '0;
    logic [3:0] i_field = '0;
    logic       i_sop = 1'b0;
    logic       i_eop = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] o_data;
    logic [3:0] o_field;
    logic       o_sop;
    logic       o_eop;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_err;

    genie_pipe_stage #(.WIDTH_DATA(8), .WIDTH_FIELD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_field (i_field),
        .i_sop   (i_sop),
        .i_eop   (i_eop),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_field (o_field),
        .o_sop   (o_sop),
        .o_eop   (o_eop),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          n_emit = 0;
    logic [13:0] exp_q[$];
    int          acc_cyc[$];
    int          emit_cyc[$];
    logic        rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample just before each rising edge, pop and compare on emit
    initial begin
        logic        hold;
        logic [13:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", {31'd0, o_valid}, 32'd1);
                    chk("hold_beat", {18'd0, o_data, o_field, o_sop, o_eop}, {18'd0, held});
                end
                if (o_valid && i_ready) begin
                    n_emit++;
                    emit_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", {18'd0, o_data, o_field, o_sop, o_eop}, 32'hFFFF_FFFF);
                    end else begin
                        chk("beat", {18'd0, o_data, o_field, o_sop, o_eop}, {18'd0, exp_q.pop_front()});
                    end
                end
                hold = o_valid && !i_ready;
                held = {o_data, o_field, o_sop, o_eop};
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] f, input logic s, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        i_data = d; i_field = f; i_sop = s; i_eop = e; i_valid = 1'b1;
        while (1) begin
            #4;
            if (o_ready) begin
                exp_q.push_back({d, f, s, e});
                acc_cyc.push_back(cyc);
                break;
            end
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #4;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        sample();
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        exp_q.delete();
        acc_cyc.delete();
        emit_cyc.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release and back-to-back 3-beat packet
        do_reset();
        #4;
        chk("ready_before_edge", {31'd0, o_ready}, 32'd0);
        sample();
        chk("ready_after_edge", {31'd0, o_ready}, 32'd1);
        chk("valid_after_reset", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        send(8'h11, 4'h5, 1'b1, 1'b0);
        send(8'h22, 4'h5, 1'b0, 1'b0);
        send(8'h33, 4'h5, 1'b0, 1'b1);
        idle();
        drain();
        chk("t1_emits", emit_cyc.size(), 32'd3);
        for (int i = 0; i < 3 && i < emit_cyc.size() && i < acc_cyc.size(); i++) begin
            chk("t1_latency", emit_cyc[i], acc_cyc[i] + 1);
        end
        chk("t1_err", {31'd0, o_err}, 32'd0);

        // Backpressure: fill to FULL, hold third beat off, then release
        i_ready = 1'b0;
        send(8'h11, 4'h5, 1'b1, 1'b0);
        send(8'h22, 4'h5, 1'b0, 1'b0);
        fork
            send(8'h33, 4'h5, 1'b0, 1'b1);
            begin
                repeat (4) begin
                    sample();
                    chk("t2_ready_low", {31'd0, o_ready}, 32'd0);
                    chk("t2_data_hold", {24'd0, o_data}, 32'h11);
                end
                @(negedge clk);
                i_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("t2_ready_back", {31'd0, o_ready}, 32'd1);
        chk("t2_err", {31'd0, o_err}, 32'd0);

        // Random valid/ready, single-beat packets, incrementing data
        n_emit = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    while ($urandom_range(0, 1) == 1) begin
                        @(negedge clk);
                        i_valid = 1'b0;
                    end
                    send(k[7:0], k[3:0], 1'b1, 1'b1);
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    i_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        drain();
        chk("t3_count", n_emit, 32'd1000);
        chk("t3_err", {31'd0, o_err}, 32'd0);

        // Beat without sop while IDLE
        send(8'h44, 4'h2, 1'b0, 1'b0);
        idle();
        #4;
        chk("t4_err_set", {31'd0, o_err}, 32'd1);
        drain();
        repeat (3) sample();
        chk("t4_err_sticky", {31'd0, o_err}, 32'd1);

        // Field change mid-packet
        do_reset();
        i_ready = 1'b1;
        send(8'h51, 4'h5, 1'b1, 1'b0);
        idle();
        sample();
        chk("t5_err_clean", {31'd0, o_err}, 32'd0);
        send(8'h52, 4'h6, 1'b0, 1'b1);
        idle();
        #4;
        chk("t5_err_field", {31'd0, o_err}, 32'd1);
        drain();

        // Second sop before eop
        do_reset();
        i_ready = 1'b1;
        send(8'h61, 4'h3, 1'b1, 1'b0);
        send(8'h62, 4'h3, 1'b0, 1'b0);
        idle();
        sample();
        chk("t5b_err_clean", {31'd0, o_err}, 32'd0);
        send(8'h63, 4'h3, 1'b1, 1'b0);
        send(8'h64, 4'h3, 1'b0, 1'b1);
        idle();
        #4;
        chk("t5b_err_sop", {31'd0, o_err}, 32'd1);
        drain();

        // Reset while FULL discards held beats
        do_reset();
        i_ready = 1'b0;
        send(8'h71, 4'h1, 1'b1, 1'b0);
        send(8'h72, 4'h1, 1'b0, 1'b1);
        idle();
        #4;
        chk("t6_full_ready", {31'd0, o_ready}, 32'd0);
        chk("t6_full_valid", {31'd0, o_valid}, 32'd1);
        do_reset();
        i_ready = 1'b1;
        repeat (5) begin
            sample();
            chk("t6_no_stale", {31'd0, o_valid}, 32'd0);
        end
        chk("t6_ready", {31'd0, o_ready}, 32'd1);
        chk("t6_err", {31'd0, o_err}, 32'd0);
        chk("t6_emits", n_emit, 32'd1000 + 32'd1 + 32'd2 + 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/genie_pipe_stage.md
Name: genie_pipe_stage

Overview:
- Registered elastic pipeline stage that sits directly downstream of the field-conversion stage.
- Carries the pass-through data word, the converted field and packet delimiters (sop/eop) across a valid/ready boundary.
- Registers all outputs, including the upstream ready, to break timing paths between interconnect stages.
- Polices packet framing and field stability on accepted beats and raises a sticky error flag on any violation.

Parameters:
- WIDTH_DATA, 8, width of carried data word.
- WIDTH_FIELD, 4, width of converted field (the upstream output-field width).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_data  in  WIDTH_DATA  upstream data word.
- i_field  in  WIDTH_FIELD  upstream converted field.
- i_sop  in  1  first beat of packet.
- i_eop  in  1  last beat of packet.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat this cycle (registered).
- o_data  out  WIDTH_DATA  downstream data word.
- o_field  out  WIDTH_FIELD  downstream field.
- o_sop  out  1  downstream sop.
- o_eop  out  1  downstream eop.
- o_valid  out  1  downstream beat valid (registered).
- i_ready  in  1  downstream accepts the beat.
- o_err  out  1  sticky framing/field error.

Behaviour:
- Reset (reset=0, async): o_valid=0, o_ready=0, o_err=0, o_data/o_field/o_sop/o_eop=0, both entries empty, checker in IDLE.
- o_ready rises on the first clk edge after reset is released. Asserting reset mid-operation discards all held beats immediately.
- Handshakes:
  - Accept when i_valid && o_ready.
  - Emit when o_valid && i_ready.
  - i_valid while o_ready=0: the beat is not accepted, no state change.
- Storage: main entry M drives the outputs; skid entry S. Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY + accept → ONE; o_valid=1 the next cycle (latency 1).
  - ONE + accept + emit → ONE; M reloads with the new beat. This sustains one beat per cycle.
  - ONE + accept, no emit → FULL; new beat goes into S; o_ready=0 the next cycle.
  - ONE + emit, no accept → EMPTY.
  - FULL + emit → ONE; S moves to M; o_ready=1 the next cycle.
  - FULL never accepts, because o_ready=0.
- o_ready = registered (next occupancy < 2). Ordering is strictly FIFO. Data, field, sop and eop pass through bit-exact.
- Outputs hold stable while o_valid && !i_ready.
- Packet checker, evaluated on accepted beats only. States: IDLE, IN_PKT; holds a latched field L.
  - IDLE, sop && eop: single-beat packet; stay IDLE.
  - IDLE, sop && !eop: go to IN_PKT; L := i_field.
  - IDLE, !sop: error; stay IDLE.
  - IN_PKT, sop: error; restart with L := i_field, go to IN_PKT (or IDLE if eop also set).
  - IN_PKT, i_field != L: error.
  - IN_PKT, eop: go to IDLE.
  - o_err is set the cycle after the offending accept and clears only on reset.
  - Errored beats are still forwarded unchanged.
- Simultaneous accept and emit in any state are legal and never drop or duplicate a beat.

Decomposition:
- genie_pkg holds:
  - typedef enum {OCC_EMPTY, OCC_ONE, OCC_FULL} genie_occ_t;
  - typedef enum {PKT_IDLE, PKT_IN} genie_pkt_state_t.
- Sub-module genie_pkt_check:
  - inputs: clk, reset, accept, sop, eop, field;
  - output: err;
  - contains the IDLE/IN_PKT FSM and field latch.
- The top level contains the skid datapath and occupancy FSM.

Test Plan:
- Reset release, i_ready=1, 3-beat packet (data 0x11/0x22/0x33, field 0x5, sop on beat 1, eop on beat 3), presented back-to-back → o_ready=1 one cycle after reset. The same 3 beats appear one cycle later, consecutive cycles, o_err=0.
- i_ready=0 while 2 beats are accepted → o_ready=0 after the second accept, the third beat is held off upstream, o_data=0x11 stays stable. Raise i_ready → 0x22 then 0x33 emitted, o_ready back to 1.
- Random i_valid/i_ready at 50% over 1000 beats with an incrementing data pattern → output sequence exactly equals input sequence, no loss or duplication.
- Beat with i_sop=0 while IDLE (data 0x44) → beat forwarded, o_err=1 the next cycle and stays 1.
- Packet with field 0x5 on beat 1 and 0x6 on beat 2 → o_err=1 after beat 2 is accepted. Separately, a second sop before eop → o_err=1.
- Reset asserted while FULL → o_valid=0 and o_ready=0 immediately. After release, no stale beat is emitted and o_err=0.
